// File: rtl/slc3_btn_pkg.sv
// rtl/slc3_btn_pkg.sv - shared types and constants for the SLC-3 key front end
package slc3_btn_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int SYNC_STAGES = 2;

   // The debounced level is high in both states that follow an accepted press.
   function automatic logic state_is_down(input btn_state_t s);
      return (s == PRESSED) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer and debounce FSM for one active-low key
module btn_debounce
   import slc3_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic level_o,
   output logic level_nxt_o,
   output logic rise_o,
   output logic pressed_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_s;
   btn_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   level_q, level_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_ni};
      end
   end

   assign key_s = sync_q[SYNC_STAGES-1];

   // Saturating increment so the counter can never wrap back into range.
   assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RELEASED: begin
            if (!key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_LAST) begin
                  state_d = PRESSED;
               end
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_s) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_LAST) begin
                  state_d = RELEASED;
               end
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_d = state_is_down(state_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level_o     = level_q;
   assign level_nxt_o = level_d;
   assign rise_o      = level_d & ~level_q;
   assign pressed_o   = (state_q == PRESSED);

endmodule

// File: rtl/slc3_button_conditioner.sv
// rtl/slc3_button_conditioner.sv - Run/Continue key conditioning, pulses and reset combo
// Optional Continue auto-repeat is enabled by defining SLC3_CONTINUE_REPEAT_EN.
module slc3_button_conditioner
   import slc3_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic Continue,
   output logic Run_ah,
   output logic Continue_ah,
   output logic Reset_ah,
   output logic Run_pulse,
   output logic Continue_pulse
);

   logic run_level, run_level_nxt, run_rise;
   logic cont_level, cont_level_nxt, cont_rise, cont_pressed;
   logic unused_run_pressed;
   logic cont_fire;
   logic run_pulse_q, run_pulse_d;
   logic cont_pulse_q, cont_pulse_d;
   logic reset_ah_q, reset_ah_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_run_db (
      .clk_i       (Clk),
      .rst_ni      (Reset_n),
      .key_ni      (Run),
      .level_o     (run_level),
      .level_nxt_o (run_level_nxt),
      .rise_o      (run_rise),
      .pressed_o   (unused_run_pressed)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_cont_db (
      .clk_i       (Clk),
      .rst_ni      (Reset_n),
      .key_ni      (Continue),
      .level_o     (cont_level),
      .level_nxt_o (cont_level_nxt),
      .rise_o      (cont_rise),
      .pressed_o   (cont_pressed)
   );

`ifdef SLC3_CONTINUE_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);

   logic [REP_W-1:0] rep_q, rep_d;
   logic             rep_run;
   logic             rep_fire;

   // Counting starts the cycle before the initial pulse, so reaching
   // REP_LAST lands each repeat exactly REPEAT_CYCLES after the previous one.
   assign rep_run  = cont_pressed & ~run_level;
   assign rep_fire = rep_run && (rep_q == REP_LAST);

   always_comb begin
      rep_d = '0;
      if (rep_run) begin
         rep_d = rep_fire ? REP_W'(1) : rep_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign cont_fire = cont_rise | rep_fire;
`else
   logic unused_repeat;
   assign unused_repeat = cont_pressed & (REPEAT_CYCLES != 0);
   assign cont_fire     = cont_rise;
`endif

   // A key's pulse is dropped when the other key is, or is just becoming, down.
   assign run_pulse_d  = run_rise  & ~(cont_level | cont_level_nxt);
   assign cont_pulse_d = cont_fire & ~(run_level  | run_level_nxt);
   assign reset_ah_d   = run_level_nxt & cont_level_nxt;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         run_pulse_q  <= 1'b0;
         cont_pulse_q <= 1'b0;
         reset_ah_q   <= 1'b0;
      end else begin
         run_pulse_q  <= run_pulse_d;
         cont_pulse_q <= cont_pulse_d;
         reset_ah_q   <= reset_ah_d;
      end
   end

   assign Run_ah         = run_level;
   assign Continue_ah    = cont_level;
   assign Reset_ah       = reset_ah_q;
   assign Run_pulse      = run_pulse_q;
   assign Continue_pulse = cont_pulse_q;

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// tb/tb_slc3_button_conditioner.sv - self-checking bench for slc3_button_conditioner
module tb_slc3_button_conditioner;

   localparam int D = 4;
   localparam int R = 20;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic Run = 1'b1;
   logic Continue = 1'b1;
   logic Run_ah, Continue_ah, Reset_ah, Run_pulse, Continue_pulse;

   int checks = 0;
   int errors = 0;

   slc3_button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .Run            (Run),
      .Continue       (Continue),
      .Run_ah         (Run_ah),
      .Continue_ah    (Continue_ah),
      .Reset_ah       (Reset_ah),
      .Run_pulse      (Run_pulse),
      .Continue_pulse (Continue_pulse)
   );

   always #5 Clk = ~Clk;

   // Reference model: raw key seen two edges late; the accepted level flips once
   // D consecutive synchronized samples disagree with it; outputs lag one edge.
   bit [1:0] m_d1, m_d2, m_st, ah_prev;
   int       m_dis [2];
   int       m_rep;
   bit [1:0] e_ah, e_pulse;
   bit       e_rst;

   int tick_no, run_pulse_n, cont_pulse_n, cont_ah_n;
   int run_rise_at, cont_rise_at, rst_rise_at, rst_fall_at;
   logic p_run_ah, p_cont_ah, p_rst;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (tick %0d)", tag, obs, exp, tick_no);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_d1 = 2'b11; m_d2 = 2'b11; m_st = 2'b00; ah_prev = 2'b00;
      m_dis[0] = 0; m_dis[1] = 0; m_rep = 0;
      e_ah = 2'b00; e_pulse = 2'b00; e_rst = 1'b0;
   endtask

   task automatic model_edge(input bit [1:0] raw);
      bit [1:0] now_v;
      bit       cont_held, fire, samp;
      cont_held = m_st[1] && (m_dis[1] == 0);
      now_v = m_st;
      for (int k = 0; k < 2; k++) begin
         samp = ~m_d2[k];
         if (samp != m_st[k]) begin
            m_dis[k]++;
            if (m_dis[k] == D) begin
               m_st[k]  = samp;
               m_dis[k] = 0;
            end
         end else begin
            m_dis[k] = 0;
         end
      end
      m_d2 = m_d1;
      m_d1 = raw;
      fire = 1'b0;
`ifdef SLC3_CONTINUE_REPEAT_EN
      if (cont_held && !ah_prev[0]) begin
         if (m_rep == R) begin
            fire  = 1'b1;
            m_rep = 1;
         end else begin
            m_rep++;
         end
      end else begin
         m_rep = 0;
      end
`else
      if (cont_held) m_rep = 0;
`endif
      e_ah       = now_v;
      e_rst      = now_v[0] & now_v[1];
      e_pulse[0] = now_v[0] & ~ah_prev[0] & ~(ah_prev[1] | now_v[1]);
      e_pulse[1] = ((now_v[1] & ~ah_prev[1]) | fire) & ~(ah_prev[0] | now_v[0]);
      ah_prev    = now_v;
   endtask

   task automatic check_all();
      chk("run_ah", Run_ah, e_ah[0]);
      chk("cont_ah", Continue_ah, e_ah[1]);
      chk("reset_ah", Reset_ah, e_rst);
      chk("run_pulse", Run_pulse, e_pulse[0]);
      chk("cont_pulse", Continue_pulse, e_pulse[1]);
   endtask

   task automatic clr_stats();
      tick_no = 0; run_pulse_n = 0; cont_pulse_n = 0; cont_ah_n = 0;
      run_rise_at = -1; cont_rise_at = -1; rst_rise_at = -1; rst_fall_at = -1;
      p_run_ah = Run_ah; p_cont_ah = Continue_ah; p_rst = Reset_ah;
   endtask

   task automatic tick();
      bit [1:0] raw;
      bit       rn;
      raw = {Continue, Run};
      rn  = Reset_n;
      @(posedge Clk);
      if (rn) model_edge(raw);
      else    model_reset();
      #1;
      tick_no++;
      check_all();
      if (Run_pulse)      run_pulse_n++;
      if (Continue_pulse) cont_pulse_n++;
      if (Continue_ah)    cont_ah_n++;
      if (Run_ah && !p_run_ah && run_rise_at < 0)       run_rise_at  = tick_no;
      if (Continue_ah && !p_cont_ah && cont_rise_at < 0) cont_rise_at = tick_no;
      if (Reset_ah && !p_rst && rst_rise_at < 0)        rst_rise_at  = tick_no;
      if (!Reset_ah && p_rst && rst_fall_at < 0)        rst_fall_at  = tick_no;
      p_run_ah = Run_ah; p_cont_ah = Continue_ah; p_rst = Reset_ah;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic async_reset_pulse();
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      Reset_n = 1'b1;
   endtask

   initial begin
      int hold_run, hold_cont;
      model_reset();
      clr_stats();
      #1;
      check_all();
      ticks(3);
      Reset_n = 1'b1;
      ticks(6);

      // Run held: 7-cycle latency, single pulse, other outputs quiet
      clr_stats();
      Run = 1'b0;
      ticks(20);
      chk_int("run_latency", run_rise_at, 7);
      chk_int("run_pulse_count", run_pulse_n, 1);
      chk_int("run_only_cont_pulses", cont_pulse_n, 0);
      Run = 1'b1;
      ticks(12);

      // Continue chatter shorter than the debounce window
      clr_stats();
      for (int i = 0; i < 10; i++) begin
         Continue = 1'b0; ticks(2);
         Continue = 1'b1; ticks(2);
      end
      chk_int("chatter_cont_ah", cont_ah_n, 0);
      chk_int("chatter_cont_pulse", cont_pulse_n, 0);
      ticks(6);

      // Run then Continue: reset combo, release Run without a Continue pulse
      clr_stats();
      Run = 1'b0;
      ticks(10);
      chk_int("combo_run_pulse", run_pulse_n, 1);
      clr_stats();
      Continue = 1'b0;
      ticks(12);
      chk_int("combo_reset_rise", rst_rise_at, 7);
      chk_int("combo_cont_pulse", cont_pulse_n, 0);
      clr_stats();
      Run = 1'b1;
      ticks(10);
      chk_int("combo_reset_fall", rst_fall_at, 7);
      chk("combo_cont_still_held", Continue_ah, 1'b1);
      chk_int("combo_release_pulses", run_pulse_n + cont_pulse_n, 0);
      Continue = 1'b1;
      ticks(10);

      // Simultaneous press
      clr_stats();
      Run = 1'b0; Continue = 1'b0;
      ticks(10);
      chk_int("simul_run_rise", run_rise_at, 7);
      chk_int("simul_cont_rise", cont_rise_at, 7);
      chk_int("simul_reset_rise", rst_rise_at, 7);
      chk_int("simul_pulses", run_pulse_n + cont_pulse_n, 0);
      Run = 1'b1; Continue = 1'b1;
      ticks(10);

      // Reset mid-debounce with Run still held
      clr_stats();
      Run = 1'b0;
      ticks(5);
      async_reset_pulse();
      clr_stats();
      ticks(10);
      chk_int("rereq_latency", run_rise_at, 7);
      chk_int("rereq_pulse", run_pulse_n, 1);
      Run = 1'b1;
      ticks(10);

      // Continue held long: one pulse, or auto-repeat every R cycles
      clr_stats();
      Continue = 1'b0;
      ticks(70);
`ifdef SLC3_CONTINUE_REPEAT_EN
      chk_int("hold_cont_pulses", cont_pulse_n, 4);
`else
      chk_int("hold_cont_pulses", cont_pulse_n, 1);
`endif
      Continue = 1'b1;
      ticks(10);

      // Randomized key activity with occasional asynchronous resets
      hold_run = 1;
      hold_cont = 1;
      for (int i = 0; i < 800; i++) begin
         if (--hold_run == 0) begin
            Run = ~Run;
            hold_run = $urandom_range(1, 12);
         end
         if (--hold_cont == 0) begin
            Continue = ~Continue;
            hold_cont = $urandom_range(1, 12);
         end
         if ($urandom_range(0, 199) == 0) async_reset_pulse();
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
